// File: rtl/data_bus_pkg.sv
// Shared types and funct3 encodings for the data-memory bus adapter.
package data_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

endpackage

// File: rtl/data_bus_adapter_aligner.sv
// Combinational lane logic: byte enables and replicated store data on the way out,
// lane selection and sign/zero extension of the returned word on the way in.
module load_store_aligner
    import data_bus_pkg::*;
(
    input  logic [2:0]  format,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] write_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_enable,
    output logic [31:0] write_data_rep,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Unsupported funct3 encodings are reported through misalign as well.
    always_comb begin
        byte_enable    = 4'b0000;
        write_data_rep = write_data;
        misalign       = 1'b0;
        case (format)
            FMT_B, FMT_BU: begin
                byte_enable    = 4'b0001 << addr_lo;
                write_data_rep = {4{write_data[7:0]}};
            end
            FMT_H, FMT_HU: begin
                byte_enable    = 4'b0011 << addr_lo;
                write_data_rep = {2{write_data[15:0]}};
                misalign       = addr_lo[0];
            end
            FMT_W: begin
                byte_enable = 4'b1111;
                misalign    = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte  = read_word[8*addr_lo +: 8];
        sel_half  = addr_lo[1] ? read_word[31:16] : read_word[15:0];
        load_data = 32'd0;
        case (format)
            FMT_B:   load_data = {{24{sel_byte[7]}}, sel_byte};
            FMT_BU:  load_data = {24'd0, sel_byte};
            FMT_H:   load_data = {{16{sel_half[15]}}, sel_half};
            FMT_HU:  load_data = {16'd0, sel_half};
            FMT_W:   load_data = read_word;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_bus_adapter.sv
// Turns each core load/store into one valid/ready bus transaction, stalling the core
// until the response arrives, and reports misaligned, illegal or timed-out accesses.
module data_bus_adapter
    import data_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_read_enable,
    input  logic        core_write_enable,
    input  logic [31:0] core_address,
    input  logic [31:0] core_write_data,
    input  logic [2:0]  core_format,
    output logic [31:0] core_read_data,
    output logic        core_stall,
    output logic        core_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_address,
    output logic        bus_write_enable,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               fault_q;
    logic [31:0]        addr_q;
    logic [2:0]         fmt_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rsp_q;

    logic [2:0]         fmt_sel;
    logic [1:0]         addr_lo_sel;
    logic [3:0]         al_be;
    logic [31:0]        al_wdata;
    logic               al_misalign;
    logic [31:0]        al_load;
    logic               req, illegal, timeout;

    // The aligner looks at the live request while idle and at the captured one afterwards.
    assign fmt_sel     = (state_q == ST_IDLE) ? core_format : fmt_q;
    assign addr_lo_sel = (state_q == ST_IDLE) ? core_address[1:0] : addr_q[1:0];

    load_store_aligner u_aligner (
        .format         (fmt_sel),
        .addr_lo        (addr_lo_sel),
        .write_data     (core_write_data),
        .read_word      (rsp_q),
        .byte_enable    (al_be),
        .write_data_rep (al_wdata),
        .misalign       (al_misalign),
        .load_data      (al_load)
    );

    assign req     = core_read_enable | core_write_enable;
    assign illegal = al_misalign | (core_read_enable & core_write_enable)
                   | (core_write_enable & core_format[2]);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        core_stall = 1'b0;
        bus_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    core_stall = 1'b1;
                    state_d    = illegal ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                core_stall = 1'b1;
                bus_valid  = 1'b1;
                if (timeout)        state_d = ST_DONE;
                else if (bus_ready) state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                core_stall = 1'b1;
                if (bus_rsp_valid || timeout) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            core_stall = 1'b0;
            bus_valid  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                fault_q <= illegal;
                cnt_q   <= '0;
            end else if (state_q == ST_REQ || state_q == ST_WAIT_RSP) begin
                cnt_q <= cnt_q + CNT_W'(1);
                // A response arriving on the last allowed cycle still wins.
                if (timeout && !(state_q == ST_WAIT_RSP && bus_rsp_valid))
                    fault_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == ST_IDLE && req) begin
            addr_q  <= core_address;
            fmt_q   <= core_format;
            we_q    <= core_write_enable;
            be_q    <= al_be;
            wdata_q <= al_wdata;
        end
        if (state_q == ST_WAIT_RSP && bus_rsp_valid)
            rsp_q <= bus_rsp_data;
    end

    assign bus_address      = bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_write_enable = bus_valid & we_q;
    assign bus_byte_enable  = bus_valid ? be_q : 4'd0;
    assign bus_write_data   = (bus_valid && we_q) ? wdata_q : 32'd0;

    assign core_fault     = (state_q == ST_DONE) && fault_q && !reset;
    assign core_read_data = ((state_q == ST_DONE) && !fault_q && !we_q && !reset)
                          ? al_load : 32'd0;

endmodule

// File: doc/data_bus_adapter.md
# data_bus_adapter

Bridges the data-memory port of the single-cycle datapath to a word-oriented memory bus with valid/ready request and response handshakes. It sits directly downstream of the datapath's load/store outputs (address, write data, funct3 format). It turns each load/store into one bus transaction with byte enables. It stalls the core until the transaction completes, then returns aligned and extended load data, or raises a fault for misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT_RSP before a timeout fault; must be ≥1.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- core_read_enable  input  1  core requests a load this cycle.
- core_write_enable  input  1  core requests a store this cycle (both high is an illegal request and raises a fault).
- core_address  input  32  byte address from the ALU result.
- core_write_data  input  32  store data (rs2), low-aligned.
- core_format  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- core_read_data  output  32  extended load data; valid in DONE only, else 0.
- core_stall  output  1  hold PC and register file; core keeps request inputs stable while high.
- core_fault  output  1  one-cycle pulse in DONE when the access faulted.
- bus_valid  output  1  request valid.
- bus_ready  input  1  request accepted when bus_valid && bus_ready.
- bus_address  output  32  word address (core_address with [1:0] = 00).
- bus_write_enable  output  1  1 = store, 0 = load.
- bus_byte_enable  output  4  active byte lanes.
- bus_write_data  output  32  lane-replicated store data.
- bus_rsp_valid  input  1  response or store acknowledge.
- bus_rsp_data  input  32  raw read word.

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: with no request, all outputs 0. With a request, core_stall = 1 combinationally and the address, data, format and direction are registered.
  - Legal request → REQ.
  - Illegal request (fault flag set) → DONE. Illegal means: misaligned H/HU (addr[0] = 1), misaligned W (addr[1:0] ≠ 00), stores with format 1xx, format 011/110/111, or both enables high.
- REQ: bus_valid = 1 and bus outputs driven from registers, held stable until accepted. On bus_ready → WAIT_RSP.
- WAIT_RSP: bus_valid = 0. On bus_rsp_valid, capture bus_rsp_data → DONE.
- DONE: core_stall = 0 and core_read_data is driven, so the core commits at this edge. core_fault = fault flag. Next state is IDLE.
- Timeout counter:
  - cleared on entering REQ; increments each cycle in REQ or WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES → DONE with fault; bus_valid drops in DONE.
- bus_rsp_valid outside WAIT_RSP is ignored (late responses are dropped).
- Byte enables:
  - B/BU: 0001 << addr[1:0]
  - H/HU: 0011 << addr[1:0]
  - W: 1111
  - Loads use the same enables.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Load data: byte lane addr[1:0] or half lane addr[1], sign-extended for B/H, zero-extended for BU/HU.
- Faulted access: core_read_data = 0, no register capture of bus data.

## Timing
- Reset: state IDLE, counter 0, fault flag 0. All outputs are 0 while reset is high, including core_stall.
- Reset mid-transaction: the next cycle is IDLE with bus_valid = 0. Any outstanding response is ignored.
- Zero-wait bus (ready in the REQ cycle, response the next cycle): IDLE → REQ → WAIT_RSP → DONE, so the core is stalled 3 cycles and commits on the 4th.
- Misaligned access: IDLE → DONE, stalled 1 cycle, fault pulse on cycle 2, no bus activity.
- Back-to-back accesses: one IDLE cycle is always present between transactions.
- Address, enables and data are registered, so there is no combinational path from core inputs to bus outputs. core_stall is combinational from state and the core enables.

## Structure
- Package data_bus_pkg:
  - state enum typedef.
  - funct3 format constants (FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU).
- Sub-module load_store_aligner, purely combinational:
  - format + addr[1:0] + write data → byte enables, replicated write data, misalign flag.
  - format + addr[1:0] + raw word → extended load data.
- The FSM, timeout counter and capture registers stay in data_bus_adapter.

## Test plan
- LB at 0x103, rsp_data 0x80FF_0000, zero-wait bus → byte_enable 1000, bus_address 0x100, core_read_data 0xFFFF_FF80 in DONE, stall exactly 3 cycles.
- SH at 0x202 with write_data 0x1234_ABCD → bus_write_data 0xABCD_ABCD, byte_enable 1100, bus_write_enable 1; commit on ack.
- LHU at 0x301 → no bus_valid, core_fault = 1 for one cycle, read_data 0.
- LW with bus_ready held low 3 cycles → bus_valid and address stable throughout; rsp 0xDEAD_BEEF is returned unchanged.
- No response, TIMEOUT_CYCLES = 4 → fault pulse after 4 cycles in REQ/WAIT_RSP. A late rsp_valid in IDLE has no effect.
- Reset asserted in WAIT_RSP → next cycle IDLE with all outputs 0; a following LBU at 0x0 with rsp_data 0x0000_0090 returns 0x0000_0090.
